// File: rtl/neural_sim_pkg.sv
// Shared types and defaults for the neural dataset simulator playback sequencer.
package neural_sim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REWIND,
    ST_RUN,
    ST_GAP,
    ST_FINISH
  } state_t;

  localparam int DEF_DATA_W  = 12;
  localparam int DEF_RST_CYC = 6;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/neural_sim_sequencer_if.sv
// Simulator-facing control/sample bus plus the forwarded sample stream.
interface neural_sim_sequencer_if
  import neural_sim_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic                     SIM_nRST;
  logic                     SIM_EN;
  logic signed [DATA_W-1:0] SIM_DATA;
  logic                     SIM_END;
  logic signed [DATA_W-1:0] DATA_OUT;
  logic                     DATA_VALID;

  modport master (
    output SIM_nRST, SIM_EN, DATA_OUT, DATA_VALID,
    input  SIM_DATA, SIM_END
  );

  modport slave (
    input  SIM_nRST, SIM_EN, DATA_OUT, DATA_VALID,
    output SIM_DATA, SIM_END
  );
endinterface

// File: rtl/sim_cycle_timer.sv
// Loadable down-counter with zero flag; times both the rewind pulse and the inter-loop gap.
module sim_cycle_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/neural_sim_sequencer.sv
// Playback controller: rewinds the simulator, forwards samples one cycle late, loops with idle gaps.
module neural_sim_sequencer
  import neural_sim_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LOOP_W  = 8,
  parameter int RST_CYC = DEF_RST_CYC,
  parameter int GAP_CYC = 16,
  parameter int CNT_W   = 32
) (
  input  logic                   CLK_ADC,
  input  logic                   RST,
  input  logic                   START,
  input  logic                   ABORT,
  input  logic [LOOP_W-1:0]      LOOPS,
  neural_sim_sequencer_if.master sim,
  output logic [LOOP_W-1:0]      LOOP_IDX,
  output logic [CNT_W-1:0]       SAMPLE_CNT,
  output logic                   BUSY,
  output logic                   DONE
);

  localparam int TMR_W = $clog2(max_int(RST_CYC, GAP_CYC) + 1);
  localparam logic [TMR_W-1:0] RW_LOAD  = TMR_W'(RST_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  state_t                   r_state;
  logic [LOOP_W-1:0]        r_loops;
  logic [LOOP_W-1:0]        r_loop_idx;
  logic [CNT_W-1:0]         r_sample_cnt;
  logic signed [DATA_W-1:0] r_data_out;
  logic                     r_data_vld;
  logic                     r_sim_nrst;
  logic                     r_sim_en;
  logic                     r_busy;
  logic                     r_done;

  logic [LOOP_W-1:0]        w_idx_inc;
  logic                     w_last;
  logic                     w_cnt_sat;
  logic                     w_tmr_load;
  logic [TMR_W-1:0]         w_tmr_val;
  logic                     w_tmr_zero;

  assign w_idx_inc = r_loop_idx + LOOP_W'(1);
  assign w_last    = (r_loops != '0) && (w_idx_inc == r_loops);
  assign w_cnt_sat = &r_sample_cnt;

  // Timer is loaded on every entry into REWIND or GAP so its zero flag marks the last cycle there.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = RW_LOAD;
    case (r_state)
      ST_IDLE: w_tmr_load = START;
      ST_RUN: begin
        if (sim.SIM_END && !w_last) begin
          w_tmr_load = 1'b1;
          if (GAP_CYC != 0) w_tmr_val = GAP_LOAD;
        end
      end
      ST_GAP:  w_tmr_load = w_tmr_zero;
      default: w_tmr_load = 1'b0;
    endcase
  end

  sim_cycle_timer #(.W(TMR_W)) u_timer (
    .clk        (CLK_ADC),
    .rst        (RST),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge CLK_ADC) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_loops      <= '0;
      r_loop_idx   <= '0;
      r_sample_cnt <= '0;
      r_data_out   <= '0;
      r_data_vld   <= 1'b0;
      r_sim_nrst   <= 1'b0;
      r_sim_en     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_data_vld <= 1'b0;
      r_done     <= 1'b0;
      if (ABORT) begin
        r_state    <= ST_IDLE;
        r_sim_nrst <= 1'b0;
        r_sim_en   <= 1'b0;
        r_busy     <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (START) begin
              r_loops      <= LOOPS;
              r_loop_idx   <= '0;
              r_sample_cnt <= '0;
              r_state      <= ST_REWIND;
              r_busy       <= 1'b1;
            end
          end
          ST_REWIND: begin
            if (w_tmr_zero) begin
              r_state    <= ST_RUN;
              r_sim_nrst <= 1'b1;
              r_sim_en   <= 1'b1;
            end
          end
          ST_RUN: begin
            if (!sim.SIM_END) begin
              r_data_out <= sim.SIM_DATA;
              r_data_vld <= 1'b1;
              if (!w_cnt_sat) r_sample_cnt <= r_sample_cnt + 1'b1;
            end else begin
              r_loop_idx <= w_idx_inc;
              r_sim_en   <= 1'b0;
              if (w_last) begin
                r_state    <= ST_FINISH;
                r_sim_nrst <= 1'b0;
                r_done     <= 1'b1;
              end else if (GAP_CYC == 0) begin
                r_state    <= ST_REWIND;
                r_sim_nrst <= 1'b0;
              end else begin
                r_state <= ST_GAP;
              end
            end
          end
          ST_GAP: begin
            if (w_tmr_zero) begin
              r_state    <= ST_REWIND;
              r_sim_nrst <= 1'b0;
            end
          end
          ST_FINISH: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state    <= ST_IDLE;
            r_sim_nrst <= 1'b0;
            r_sim_en   <= 1'b0;
            r_busy     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sim.SIM_nRST   = r_sim_nrst;
  assign sim.SIM_EN     = r_sim_en;
  assign sim.DATA_OUT   = r_data_out;
  assign sim.DATA_VALID = r_data_vld;
  assign LOOP_IDX       = r_loop_idx;
  assign SAMPLE_CNT     = r_sample_cnt;
  assign BUSY           = r_busy;
  assign DONE           = r_done;

endmodule

// File: tb/tb_neural_sim_sequencer.sv
// Directed bench: scenario table of playback runs plus hand-written abort, collision and reset sequences.
module tb_neural_sim_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [7:0]  loops;
  logic [7:0]  loop_idx;
  logic [31:0] sample_cnt;
  logic        busy, done;

  initial forever #5 clk = ~clk;

  neural_sim_sequencer_if #(.DATA_W(12)) sif ();

  neural_sim_sequencer dut (
    .CLK_ADC    (clk),
    .RST        (rst),
    .START      (start),
    .ABORT      (abort),
    .LOOPS      (loops),
    .sim        (sif),
    .LOOP_IDX   (loop_idx),
    .SAMPLE_CNT (sample_cnt),
    .BUSY       (busy),
    .DONE       (done)
  );

  // Simulator model: pointer rewinds while SIM_nRST is low, advances while enabled.
  int         n_samp = 3;
  int         ptr = 0;
  logic [11:0] smem [16];

  always @(posedge clk) begin
    if (!sif.SIM_nRST) ptr <= 0;
    else if (sif.SIM_EN && ptr < n_samp) ptr <= ptr + 1;
  end

  assign sif.SIM_END  = (ptr >= n_samp);
  assign sif.SIM_DATA = smem[ptr[3:0]];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  bit          mon_en = 0;
  logic        prev_cap = 0;
  logic [11:0] prev_data = '0;
  int          done_cnt = 0, rw_pulses = 0, gap_cnt = 0, rw_len = 0, gap_len = 0;
  logic [11:0] dv_q[$];

  always @(negedge clk) begin
    if (mon_en) begin
      check("dv_timing", {31'd0, sif.DATA_VALID}, {31'd0, prev_cap});
      if (sif.DATA_VALID && prev_cap) begin
        check("dv_data", {20'd0, sif.DATA_OUT}, {20'd0, prev_data});
        dv_q.push_back(sif.DATA_OUT);
      end
      if (done) done_cnt++;
      if (busy && !done && !sif.SIM_nRST) rw_len++;
      else begin
        if (rw_len > 0 && busy && sif.SIM_nRST) begin
          check("rewind_len", rw_len, 6);
          rw_pulses++;
        end
        rw_len = 0;
      end
      if (busy && sif.SIM_nRST && !sif.SIM_EN) gap_len++;
      else begin
        if (gap_len > 0 && busy && !sif.SIM_nRST) begin
          check("gap_len", gap_len, 16);
          gap_cnt++;
        end
        gap_len = 0;
      end
    end
    prev_cap  = sif.SIM_EN && sif.SIM_nRST && !sif.SIM_END && !abort && !rst;
    prev_data = sif.SIM_DATA;
  end

  typedef struct {
    int loops;
    int nsamp;
    bit mid_start;
    int e_idx;
    int e_cnt;
    int e_rw;
    int e_gap;
  } vec_t;

  vec_t vt[4];

  task automatic clear_mon();
    done_cnt = 0; rw_pulses = 0; gap_cnt = 0;
    dv_q.delete();
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    n_samp = v.nsamp;
    clear_mon();
    @(posedge clk); #1;
    loops = 8'(v.loops);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (v.mid_start) begin
      for (k = 0; k < 100 && sif.SIM_EN !== 1'b1; k++) @(negedge clk);
      check("mid_start_run_seen", {31'd0, sif.SIM_EN}, 1);
      @(posedge clk); #1;
      loops = 8'(v.loops + 1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (k = 0; k < 5000 && busy !== 1'b0; k++) @(negedge clk);
    check("run_end_busy", {31'd0, busy}, 0);
    check("run_loop_idx", {24'd0, loop_idx}, v.e_idx);
    check("run_sample_cnt", sample_cnt, v.e_cnt);
    check("run_dv_count", dv_q.size(), v.e_cnt);
    check("run_done_pulses", done_cnt, 1);
    check("run_rewinds", rw_pulses, v.e_rw);
    check("run_gaps", gap_cnt, v.e_gap);
    check("run_done_low", {31'd0, done}, 0);
    if (dv_q.size() >= 3) begin
      check("run_data0", {20'd0, dv_q[0]}, 32'h7FF);
      check("run_data1", {20'd0, dv_q[1]}, 32'h800);
      check("run_data2", {20'd0, dv_q[2]}, 32'h001);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_nrst"}, {31'd0, sif.SIM_nRST}, 0);
    check({tag, "_en"}, {31'd0, sif.SIM_EN}, 0);
    check({tag, "_dout"}, {20'd0, sif.DATA_OUT}, 0);
    check({tag, "_dv"}, {31'd0, sif.DATA_VALID}, 0);
    check({tag, "_idx"}, {24'd0, loop_idx}, 0);
    check({tag, "_cnt"}, sample_cnt, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_done"}, {31'd0, done}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    smem[0] = 12'h7FF;
    smem[1] = 12'h800;
    smem[2] = 12'h001;
    for (int i = 3; i < 16; i++) smem[i] = 12'h100 + 12'(i * 7);

    //           loops nsamp mid idx cnt rw gap
    vt[0] = '{1, 3, 1'b0, 1, 3,  1, 0};
    vt[1] = '{3, 5, 1'b0, 3, 15, 3, 2};
    vt[2] = '{2, 0, 1'b0, 2, 0,  2, 1};
    vt[3] = '{1, 8, 1'b1, 1, 8,  1, 0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; loops = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1;

    // START and ABORT together in IDLE: abort wins
    start = 1'b1; abort = 1'b1; loops = 8'd5;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("collide_busy", {31'd0, busy}, 0);
    check("collide_nrst", {31'd0, sif.SIM_nRST}, 0);
    check("collide_en", {31'd0, sif.SIM_EN}, 0);
    repeat (2) @(negedge clk);
    check("collide_busy_hold", {31'd0, busy}, 0);

    for (int i = 0; i < 4; i++) run_vec(vt[i]);

    // Infinite mode, aborted during the gap after loop 10
    n_samp = 4;
    clear_mon();
    @(posedge clk); #1;
    loops = 8'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (k = 0; k < 2000 && loop_idx !== 8'd10; k++) @(negedge clk);
    check("inf_reach10", {24'd0, loop_idx}, 10);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_en", {31'd0, sif.SIM_EN}, 0);
    check("abort_nrst", {31'd0, sif.SIM_nRST}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_idx", {24'd0, loop_idx}, 10);
    check("abort_cnt", sample_cnt, 40);
    check("abort_dv_count", dv_q.size(), 40);
    check("abort_no_done", done_cnt, 0);
    check("abort_rewinds", rw_pulses, 10);
    check("abort_gaps", gap_cnt, 9);

    // Reset in the middle of RUN after the 7th sample
    n_samp = 10;
    clear_mon();
    @(posedge clk); #1;
    loops = 8'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (k = 0; k < 200 && sample_cnt !== 32'd6; k++) @(negedge clk);
    check("midrst_reach6", sample_cnt, 6);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cnt_before", sample_cnt, 7);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");

    run_vec(vt[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
